// File: rtl/vga_pkg.sv
// Shared types and colour constants for the VGA timing / test-pattern generator.
package vga_pkg;

    typedef enum logic [1:0] {
        GRID    = 2'd0,
        BARS    = 2'd1,
        CHECKER = 2'd2,
        SOLID   = 2'd3
    } vga_mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
    localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
    localparam rgb_t BAR_CYAN    = 24'h00FFFF;
    localparam rgb_t BAR_GREEN   = 24'h00FF00;
    localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
    localparam rgb_t BAR_RED     = 24'hFF0000;
    localparam rgb_t BAR_BLUE    = 24'h0000FF;
    localparam rgb_t BAR_BLACK   = 24'h000000;

    function automatic rgb_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_if.sv
// Video output bundle; the timing generator drives it through the master modport.
interface video_if;
    logic        CLK;
    logic        HS;
    logic        VS;
    logic        BLANK;
    logic [23:0] RGB;

    modport master (output CLK, HS, VS, BLANK, RGB);
    modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern colour generator: registered RGB, one pixel_clk after its inputs.
// Free running, no backpressure; only the low coordinate bits that select a pattern are needed.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int GRID_SHIFT = 4
) (
    input  logic                pixel_clk,
    input  logic                pixel_rst,
    input  logic [GRID_SHIFT:0] x_i,
    input  logic [GRID_SHIFT:0] y_i,
    input  logic                active_i,
    input  vga_mode_e           mode_i,
    input  rgb_t                solid_i,
    input  logic [2:0]          bar_idx_i,
    output rgb_t                rgb_o
);

    rgb_t rgb_d;
    rgb_t rgb_q;

    always_comb begin
        rgb_d = BAR_BLACK;
        if (active_i) begin
            case (mode_i)
                GRID: begin
                    if ((x_i[GRID_SHIFT-1:0] == '0) || (y_i[GRID_SHIFT-1:0] == '0))
                        rgb_d = BAR_WHITE;
                end
                BARS:    rgb_d = bar_colour(bar_idx_i);
                CHECKER: begin
                    if (x_i[GRID_SHIFT] ^ y_i[GRID_SHIFT])
                        rgb_d = BAR_WHITE;
                end
                SOLID:   rgb_d = solid_i;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) rgb_q <= BAR_BLACK;
        else           rgb_q <= rgb_d;
    end

    assign rgb_o = rgb_q;

endmodule

// File: rtl/vga_timing_pattern.sv
// Parametrised VGA/LCD timing generator with per-frame selectable test pattern.
// All outputs registered, 1 pixel_clk after the h/v state they decode; free running, no backpressure.
module vga_timing_pattern
    import vga_pkg::*;
#(
    parameter int HDISP      = 800,
    parameter int VDISP      = 480,
    parameter int HFP        = 40,
    parameter int HPULSE     = 48,
    parameter int HBP        = 40,
    parameter int VFP        = 12,
    parameter int VPULSE     = 3,
    parameter int VBP        = 40,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int GRID_SHIFT = 4
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic [1:0]                 mode,
    input  logic [23:0]                solid_rgb,
    video_if.master                    video_ifm,
    output logic                       frame_start,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y
);

    localparam int HSUP    = HFP + HPULSE + HBP;
    localparam int HSIZE   = HSUP + HDISP;
    localparam int VSUP    = VFP + VPULSE + VBP;
    localparam int VSIZE   = VSUP + VDISP;
    localparam int HW      = $clog2(HSIZE);
    localparam int VW      = $clog2(VSIZE);
    localparam int XW      = $clog2(HDISP);
    localparam int YW      = $clog2(VDISP);
    localparam int BAR_LEN = HDISP / 8;
    localparam int BW      = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(HSIZE - 1);
    localparam logic [HW-1:0] H_SUP    = HW'(HSUP);
    localparam logic [HW-1:0] H_PS     = HW'(HFP);
    localparam logic [HW-1:0] H_PE     = HW'(HFP + HPULSE);
    localparam logic [VW-1:0] V_LAST   = VW'(VSIZE - 1);
    localparam logic [VW-1:0] V_SUP    = VW'(VSUP);
    localparam logic [VW-1:0] V_PS     = VW'(VFP);
    localparam logic [VW-1:0] V_PE     = VW'(VFP + VPULSE);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_LEN - 1);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    vga_mode_e     mode_q;
    rgb_t          solid_q;
    logic          hs_q, vs_q, blank_q, fs_q;
    logic [XW-1:0] pix_x_q;
    logic [YW-1:0] pix_y_q;
    rgb_t          rgb;

    logic h_end, v_end, h_act, v_act, active, frame_origin;

    always_comb begin
        h_end        = (h_q == H_LAST);
        v_end        = (v_q == V_LAST);
        h_act        = (h_q >= H_SUP);
        v_act        = (v_q >= V_SUP);
        active       = h_act && v_act;
        frame_origin = (h_q == '0) && (v_q == '0);

        h_d = h_end ? '0 : h_q + HW'(1);
        v_d = v_q;
        y_d = y_q;
        if (h_end) begin
            v_d = v_end ? '0 : v_q + VW'(1);
            y_d = (v_act && !v_end) ? y_q + YW'(1) : '0;
        end

        // x and the bar sub-counter restart at every line so each line starts at bar 0.
        x_d       = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (h_act && !h_end) begin
            x_d = x_q + XW'(1);
            if (bar_cnt_q == BAR_LAST) begin
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_cnt_d = bar_cnt_q + BW'(1);
                bar_idx_d = bar_idx_q;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_q       <= '0;
            v_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= GRID;
            solid_q   <= '0;
            hs_q      <= !HS_POL;
            vs_q      <= !VS_POL;
            blank_q   <= 1'b0;
            fs_q      <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            // Pattern selection only changes at the frame origin, so a frame never tears.
            if (frame_origin) begin
                mode_q  <= vga_mode_e'(mode);
                solid_q <= solid_rgb;
            end
            hs_q      <= ((h_q >= H_PS) && (h_q < H_PE)) ? HS_POL : !HS_POL;
            vs_q      <= ((v_q >= V_PS) && (v_q < V_PE)) ? VS_POL : !VS_POL;
            blank_q   <= active;
            fs_q      <= frame_origin;
            pix_x_q   <= active ? x_q : '0;
            pix_y_q   <= active ? y_q : '0;
        end
    end

    vga_pattern_gen #(
        .GRID_SHIFT (GRID_SHIFT)
    ) u_pattern (
        .pixel_clk (pixel_clk),
        .pixel_rst (pixel_rst),
        .x_i       (x_q[GRID_SHIFT:0]),
        .y_i       (y_q[GRID_SHIFT:0]),
        .active_i  (active),
        .mode_i    (mode_q),
        .solid_i   (solid_q),
        .bar_idx_i (bar_idx_q),
        .rgb_o     (rgb)
    );

    assign video_ifm.CLK   = pixel_clk;
    assign video_ifm.HS    = hs_q;
    assign video_ifm.VS    = vs_q;
    assign video_ifm.BLANK = blank_q;
    assign video_ifm.RGB   = rgb;
    assign frame_start     = fs_q;
    assign pix_x           = pix_x_q;
    assign pix_y           = pix_y_q;

endmodule

// File: tb/tb_vga_timing_pattern.sv
// Bench for vga_timing_pattern: two instances (active-low and active-high sync) against a frame-level model.
module tb_vga_timing_pattern;

    localparam int HDISP = 16, VDISP = 8;
    localparam int HFP = 2, HPULSE = 3, HBP = 3;
    localparam int VFP = 1, VPULSE = 2, VBP = 2;
    localparam int GS = 2;
    localparam int GP = 4;
    localparam int HSUP = HFP + HPULSE + HBP;
    localparam int VSUP = VFP + VPULSE + VBP;
    localparam int HSIZE = HSUP + HDISP;
    localparam int VSIZE = VSUP + VDISP;
    localparam int FRAME = HSIZE * VSIZE;

    logic        pixel_clk;
    logic        pixel_rst;
    logic [1:0]  mode;
    logic [23:0] solid_rgb;
    logic        fs_a, fs_b;
    logic [3:0]  px_a, px_b;
    logic [2:0]  py_a, py_b;

    video_if vif_a ();
    video_if vif_b ();

    vga_timing_pattern #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b0), .VS_POL(1'b0), .GRID_SHIFT(GS)
    ) dut_a (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode), .solid_rgb(solid_rgb),
        .video_ifm(vif_a), .frame_start(fs_a), .pix_x(px_a), .pix_y(py_a)
    );

    vga_timing_pattern #(
        .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP), .HS_POL(1'b1), .VS_POL(1'b1), .GRID_SHIFT(GS)
    ) dut_b (
        .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode), .solid_rgb(solid_rgb),
        .video_ifm(vif_b), .frame_start(fs_b), .pix_x(px_b), .pix_y(py_b)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: n_cur is the frame position whose decode is on the outputs.
    int          n_cur = 0, n_next = 0;
    bit          out_reset = 1'b1;
    int          lm = 0;
    logic [23:0] ls = '0;
    int          cyc = 0, last_fs = -1, blank_cnt = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] solid;
        int          x;
        int          y;
        logic [23:0] exp_rgb;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    function automatic logic [23:0] exp_rgb(input int n);
        int h, v, x, y;
        h = n % HSIZE;
        v = n / HSIZE;
        if (h < HSUP || v < VSUP) return 24'h0;
        x = h - HSUP;
        y = v - VSUP;
        case (lm)
            0:       return ((x % GP) == 0 || (y % GP) == 0) ? 24'hFFFFFF : 24'h0;
            1:       return bar_tab[x / (HDISP / 8)];
            2:       return (((x / GP) % 2) != ((y / GP) % 2)) ? 24'hFFFFFF : 24'h0;
            default: return ls;
        endcase
    endfunction

    task automatic check_outputs();
        int h, v;
        bit act, hp, vp;
        logic [23:0] er;
        logic [3:0] ex;
        logic [2:0] ey;
        h = n_cur % HSIZE;
        v = n_cur / HSIZE;
        act = !out_reset && h >= HSUP && v >= VSUP;
        hp  = !out_reset && h >= HFP && h < HFP + HPULSE;
        vp  = !out_reset && v >= VFP && v < VFP + VPULSE;
        er  = out_reset ? 24'h0 : exp_rgb(n_cur);
        ex  = act ? 4'(h - HSUP) : 4'd0;
        ey  = act ? 3'(v - VSUP) : 3'd0;
        chk("fs_a",    32'(fs_a), 32'(!out_reset && n_cur == 0));
        chk("fs_b",    32'(fs_b), 32'(!out_reset && n_cur == 0));
        chk("hs_a",    32'(vif_a.HS), 32'(!hp));
        chk("hs_b",    32'(vif_b.HS), 32'(hp));
        chk("vs_a",    32'(vif_a.VS), 32'(!vp));
        chk("vs_b",    32'(vif_b.VS), 32'(vp));
        chk("blank_a", 32'(vif_a.BLANK), 32'(act));
        chk("blank_b", 32'(vif_b.BLANK), 32'(act));
        chk("rgb_a",   32'(vif_a.RGB), 32'(er));
        chk("rgb_b",   32'(vif_b.RGB), 32'(er));
        chk("pix_x_a", 32'(px_a), 32'(ex));
        chk("pix_y_a", 32'(py_a), 32'(ey));
        chk("pix_x_b", 32'(px_b), 32'(ex));
        chk("pix_y_b", 32'(py_b), 32'(ey));
    endtask

    task automatic step();
        int          m_pre;
        logic [23:0] s_pre;
        m_pre = int'(mode);
        s_pre = solid_rgb;
        @(posedge pixel_clk);
        #1;
        cyc++;
        if (!pixel_rst) begin
            out_reset = 1'b0;
            n_cur     = n_next;
            if (n_cur == 0) begin
                lm = m_pre;
                ls = s_pre;
            end
            n_next = (n_cur + 1) % FRAME;
        end
        check_outputs();
        if (!out_reset && fs_a) begin
            if (last_fs >= 0) begin
                chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
                chk("blank_count", 32'(blank_cnt), 32'(HDISP * VDISP));
            end
            last_fs   = cyc;
            blank_cnt = 0;
        end
        if (!out_reset && vif_a.BLANK) blank_cnt++;
    endtask

    task automatic run_to(input int target, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i <= FRAME; i++) begin
            if (!out_reset && n_cur == target) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout(name);
    endtask

    task automatic run_latch(input logic [1:0] m, input logic [23:0] s);
        bit ok;
        mode      = m;
        solid_rgb = s;
        ok = 1'b0;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (!out_reset && lm == int'(m) && ls == s && n_cur != 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout("mode_latch");
    endtask

    task automatic do_reset();
        pixel_rst = 1'b1;
        out_reset = 1'b1;
        n_cur     = 0;
        n_next    = 0;
        lm        = 0;
        ls        = '0;
        last_fs   = -1;
        blank_cnt = 0;
        #1;
        check_outputs();
        step();
        step();
        pixel_rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{2'd0, 24'h0,      0, 0, 24'hFFFFFF};
        vecs[1]  = '{2'd0, 24'h0,      1, 1, 24'h000000};
        vecs[2]  = '{2'd0, 24'h0,      4, 1, 24'hFFFFFF};
        vecs[3]  = '{2'd0, 24'h0,      5, 4, 24'hFFFFFF};
        vecs[4]  = '{2'd1, 24'h0,      0, 0, 24'hFFFFFF};
        vecs[5]  = '{2'd1, 24'h0,      2, 3, 24'hFFFF00};
        vecs[6]  = '{2'd1, 24'h0,      5, 7, 24'h00FFFF};
        vecs[7]  = '{2'd1, 24'h0,     11, 1, 24'hFF0000};
        vecs[8]  = '{2'd1, 24'h0,     14, 2, 24'h000000};
        vecs[9]  = '{2'd1, 24'h0,     15, 6, 24'h000000};
        vecs[10] = '{2'd2, 24'h0,      0, 0, 24'h000000};
        vecs[11] = '{2'd2, 24'h0,      4, 0, 24'hFFFFFF};
        vecs[12] = '{2'd2, 24'h0,      4, 4, 24'h000000};
        vecs[13] = '{2'd3, 24'hA5C3E1, 7, 5, 24'hA5C3E1};

        pixel_rst = 1'b1;
        mode      = 2'd0;
        solid_rgb = 24'h0;
        step();
        step();
        pixel_rst = 1'b0;

        // First edge after release decodes the frame origin.
        step();
        chk("first_fs", 32'(fs_a), 32'd1);
        repeat (3 * FRAME) step();

        foreach (vecs[i]) begin
            run_latch(vecs[i].mode, vecs[i].solid);
            run_to((vecs[i].y + VSUP) * HSIZE + vecs[i].x + HSUP, "vec_pixel");
            chk($sformatf("vec%0d_rgb", i), 32'(vif_a.RGB), 32'(vecs[i].exp_rgb));
            chk($sformatf("vec%0d_x", i), 32'(px_a), 32'(vecs[i].x));
            chk($sformatf("vec%0d_y", i), 32'(py_a), 32'(vecs[i].y));
        end

        // Mid-frame mode switch: current frame stays grid, next frame is solid.
        run_latch(2'd0, 24'h0);
        run_to(6 * HSIZE, "line6");
        mode      = 2'd3;
        solid_rgb = 24'h123456;
        run_to(6 * HSIZE + HSUP + 4, "mid_frame_pixel");
        chk("mid_frame_grid", 32'(vif_a.RGB), 32'hFFFFFF);
        run_to(0, "next_frame");
        run_to(7 * HSIZE + 3, "blank_pixel");
        chk("solid_blank_rgb", 32'(vif_a.RGB), 32'h0);
        chk("solid_blank", 32'(vif_a.BLANK), 32'h0);
        run_to(7 * HSIZE + HSUP + 5, "solid_pixel");
        chk("solid_rgb", 32'(vif_a.RGB), 32'h123456);

        // Asynchronous reset at line 7, h=10.
        run_to(7 * HSIZE + 10, "reset_point");
        do_reset();
        step();
        chk("fs_after_rst_a", 32'(fs_a), 32'd1);
        chk("fs_after_rst_b", 32'(fs_b), 32'd1);
        repeat (FRAME) step();
        chk("fs_period_after_rst", 32'(fs_a), 32'd1);

        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                mode      = 2'($urandom_range(0, 3));
                solid_rgb = 24'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
